// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory read channel between the fetch unit (master) and memory (slave)
//   imem_req  : read request, held until imem_ack
//   imem_addr : read address, valid with imem_req
//   imem_ack  : imem_data valid, at most one per request
//   imem_data : fetched instruction word
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    modport master (output imem_req, imem_addr, input imem_ack, imem_data);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: sequential instruction fetch with branch redirect, squash, stall hold and halt
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   branch_valid  : taken-branch redirect request
//   branch_target : redirect address
//   stall         : decode cannot accept an instruction this cycle
//   imem          : instruction-memory read channel (master side)
//   instr_valid   : instr/pc_out/pc_plus2 valid to decode
//   instr         : delivered instruction
//   pc_out        : address of delivered instruction
//   pc_plus2      : pc_out + 2, wrapping at 16 bits
//   halted        : fetch permanently stopped
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            branch_valid,
    input  logic [15:0]     branch_target,
    input  logic            stall,
    pc_fetch_unit_if.master imem,
    output logic            instr_valid,
    output logic [15:0]     instr,
    output logic [15:0]     pc_out,
    output logic [15:0]     pc_plus2,
    output logic            halted
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
    state_t      r_state, w_next;
    logic [15:0] r_pc, r_tgt, r_instr, r_pc_out, r_pc_plus2;
    logic        r_valid, r_squash;
    logic        w_ack, w_sq, w_take, w_redirect, w_halt_word;
    // An ack only counts while waiting; any pending or coincident branch squashes the word
    assign w_ack       = (r_state == WAIT) && imem.imem_ack;
    assign w_sq        = r_squash || branch_valid;
    assign w_take      = w_ack && !w_sq;
    assign w_redirect  = branch_valid && (r_state == IDLE || r_state == REQ || r_state == HOLD);
    assign w_halt_word = imem.imem_data[15:12] == HALT_OPCODE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = REQ;
            REQ:     w_next = branch_valid ? REQ : WAIT;
            WAIT:    w_next = !imem.imem_ack ? WAIT : !w_take ? REQ : stall ? HOLD : w_halt_word ? HALT : REQ;
            // A held halt word still halts once decode accepts it, unless a branch drops it
            HOLD:    w_next = branch_valid ? REQ : stall ? HOLD : (r_instr[15:12] == HALT_OPCODE) ? HALT : REQ;
            HALT:    w_next = HALT;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        imem.imem_req  = (r_state == REQ) || (r_state == WAIT);
        imem.imem_addr = r_pc;
        instr_valid    = r_valid;
        instr          = r_instr;
        pc_out         = r_pc_out;
        pc_plus2       = r_pc_plus2;
        // The halt word's own delivery cycle is shown as a delivery, not yet as halted
        halted         = (r_state == HALT) && !r_valid;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_tgt      <= '0;
            r_squash   <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc_out   <= '0;
            r_pc_plus2 <= '0;
        end else begin
            // PC stays put during WAIT so the request address is stable; a squashed ack picks up the recorded target
            r_pc     <= w_redirect ? branch_target :
                        w_take     ? r_pc + 16'd2  :
                        w_ack      ? (branch_valid ? branch_target : r_tgt) : r_pc;
            r_tgt    <= (r_state == WAIT && branch_valid) ? branch_target : r_tgt;
            r_squash <= (r_state == WAIT) && !imem.imem_ack && w_sq;
            r_valid  <= w_take || (r_state == HOLD && w_next == HOLD);
            if (w_take) begin
                r_instr    <= imem.imem_data;
                r_pc_out   <= r_pc;
                r_pc_plus2 <= r_pc + 16'd2;
            end
        end
    end
endmodule
